// File: rtl/beam_chan_serializer.sv
// beam_chan_serializer
// Registered N-to-1 channel selector for the beamformer datapath. One frame of
// CHANNELS parallel signed samples is taken per input handshake, then either a
// single selected channel (static mode) or every channel in index order (scan
// mode) is streamed out as valid/ready beats tagged with channel index and
// end-of-frame. Samples pass through bit-exact.
//
// Optional feature macro: BEAM_CHAN_MASK_EN
//   When defined, a per-channel enable mask (ch_mask) is captured with each
//   frame; disabled channels are skipped and frames with nothing to emit are
//   dropped without leaving IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mode       0 = static select, 1 = scan all channels (sampled on accept)
//   sel        static-mode channel (sampled on accept)
//   in_data    packed frame, channel c at [c*WIDTH +: WIDTH]
//   in_valid   frame valid
//   in_ready   frame accepted on an edge where in_valid & in_ready
//   out_data   current sample
//   out_ch     channel index of out_data
//   out_valid  beat valid
//   out_last   final beat of the frame
//   out_ready  downstream accepts the beat on an edge where out_valid & out_ready
//   busy       high while a frame still has beats to deliver
//   ch_mask    per-channel enable (BEAM_CHAN_MASK_EN only)
module beam_chan_serializer #(
    parameter  int WIDTH    = 19,
    parameter  int CHANNELS = 16,
    localparam int IDX_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [IDX_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy
`ifdef BEAM_CHAN_MASK_EN
   ,input  logic [CHANNELS-1:0]       ch_mask
`endif
);

    localparam logic [IDX_W:0]   CH_COUNT = (IDX_W+1)'(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(CHANNELS-1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] in_ch   [CHANNELS];
    logic [WIDTH-1:0] frame_q [CHANNELS];
    logic             mode_q;
    logic             accept;
    logic [IDX_W-1:0] sel_c;
    logic [IDX_W-1:0] start_idx;
    logic             start_ok;
    logic             start_last;
    logic [IDX_W-1:0] next_idx;
    logic             next_last;

`ifdef BEAM_CHAN_MASK_EN
    logic [CHANNELS-1:0] mask_q;
    logic [IDX_W-1:0]    in_first;
    logic [IDX_W-1:0]    in_hi;
    logic [IDX_W-1:0]    q_hi;
`endif

    // Unpack the flat input bus into per-channel lanes so channels can be
    // picked by index without multiplying the index by WIDTH.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
        assign in_ch[c] = in_data[c*WIDTH +: WIDTH];
    end

    // A new frame may enter when nothing is presented, or when the final beat
    // of the current frame is handshaking this very edge (back-to-back frames).
    assign in_ready = rst_n & (~out_valid | (out_valid & out_last & out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state == EMIT);

    // Out-of-range selections only exist for non-power-of-two channel counts;
    // they collapse onto the highest channel.
    assign sel_c = ({1'b0, sel} >= CH_COUNT) ? LAST_CH : sel;

    // Work out the first beat of an incoming frame and the beat that follows
    // the one currently presented. With masking, scan mode walks only enabled
    // channels and ends on the highest enabled one; without it, scan is a plain
    // 0..CHANNELS-1 walk.
    always_comb begin
        start_idx  = sel_c;
        start_ok   = 1'b1;
        start_last = 1'b1;
        next_idx   = out_ch;
        next_last  = 1'b0;
`ifdef BEAM_CHAN_MASK_EN
        in_first = '0;
        in_hi    = '0;
        q_hi     = '0;
        for (int i = CHANNELS-1; i >= 0; i--) begin
            if (ch_mask[i]) in_first = IDX_W'(i);
            if (mask_q[i] && (IDX_W'(i) > out_ch)) next_idx = IDX_W'(i);
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_mask[i]) in_hi = IDX_W'(i);
            if (mask_q[i])  q_hi  = IDX_W'(i);
        end
        next_last = (next_idx == q_hi);
        if (mode) begin
            start_idx  = in_first;
            start_ok   = |ch_mask;
            start_last = (in_first == in_hi);
        end else begin
            start_ok   = ch_mask[sel_c];
        end
`else
        next_idx  = out_ch + 1'b1;
        next_last = (next_idx == LAST_CH);
        if (mode) begin
            start_idx  = '0;
            start_last = 1'b0;
        end
`endif
    end

    // Frame buffer holds the accepted samples so upstream may change in_data
    // as soon as the frame is taken. Pure data, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < CHANNELS; i++) begin
                frame_q[i] <= in_ch[i];
            end
        end
    end

    // Control FSM and output register. An accept always wins because it can
    // only coincide with the last-beat handshake; the first beat is loaded
    // straight from in_data to give one cycle of latency. A stalled beat keeps
    // every output untouched. Static-mode beats are always final, so mode_q
    // also terminates the frame as a safeguard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            mode_q    <= 1'b0;
`ifdef BEAM_CHAN_MASK_EN
            mask_q    <= '0;
`endif
        end else if (accept) begin
            mode_q <= mode;
`ifdef BEAM_CHAN_MASK_EN
            mask_q <= ch_mask;
`endif
            if (start_ok) begin
                state     <= EMIT;
                out_valid <= 1'b1;
                out_data  <= in_ch[start_idx];
                out_ch    <= start_idx;
                out_last  <= start_last;
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            if (out_last || !mode_q) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_data  <= frame_q[next_idx];
                out_ch    <= next_idx;
                out_last  <= next_last;
            end
        end
    end

endmodule

// File: tb/tb_beam_chan_serializer.sv
// tb_beam_chan_serializer
// Self-checking bench for beam_chan_serializer. A reference model expands each
// accepted frame into the list of beats it must produce (plain channel lists
// built from mode/sel/mask) and a monitor compares the DUT against the head of
// that list every cycle, together with the expected in_ready/busy behaviour.
// Directed scenarios are followed by a randomized run with random resets.
module tb_beam_chan_serializer;

    localparam int WIDTH    = 19;
    localparam int CHANNELS = 16;
    localparam int IDX_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      mode;
    logic [IDX_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [IDX_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_last;
    logic                      out_ready;
    logic                      busy;
    logic [CHANNELS-1:0]       curMask;

`ifdef BEAM_CHAN_MASK_EN
    logic [CHANNELS-1:0]       chMask = '1;
    assign curMask = chMask;
`else
    assign curMask = {CHANNELS{1'b1}};
`endif

    always #5 clk = ~clk;

    beam_chan_serializer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef BEAM_CHAN_MASK_EN
       ,.ch_mask   (chMask)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] ch;
        logic             last;
    } beat_t;

    beat_t expQ[$];
    int    assertCount = 0;
    int    failCount   = 0;
    logic  prevReset   = 1'b0;
    logic  mPend;
    logic  mExpReady;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: list the channels a frame must emit, then turn that
    // list into beats with the end-of-frame flag on the final entry.
    function automatic void queueFrame(input logic [CHANNELS*WIDTH-1:0] data,
                                       input logic m, input logic [IDX_W-1:0] s,
                                       input logic [CHANNELS-1:0] mask);
        int    chans[$];
        int    c;
        beat_t b;
        if (!m) begin
            c = (int'(s) >= CHANNELS) ? CHANNELS-1 : int'(s);
            if (mask[c]) chans.push_back(c);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (mask[i]) chans.push_back(i);
            end
        end
        foreach (chans[k]) begin
            b.data = data[chans[k]*WIDTH +: WIDTH];
            b.ch   = IDX_W'(chans[k]);
            b.last = (k == chans.size()-1);
            expQ.push_back(b);
        end
    endfunction

    // Monitor at the falling edge: inputs are settled, so the handshakes that
    // the next rising edge will perform are already visible.
    always @(negedge clk) begin
        if (prevReset) begin
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_busy",      busy,      0);
            checkOutput("rst_out_data",  out_data,  0);
            checkOutput("rst_out_ch",    out_ch,    0);
            checkOutput("rst_out_last",  out_last,  0);
        end
        if (!rst_n) begin
            checkOutput("in_ready_reset", in_ready, 0);
            expQ.delete();
            prevReset = 1'b1;
        end else begin
            prevReset = 1'b0;
            mPend = (expQ.size() > 0);
            checkOutput("out_valid", out_valid, mPend);
            checkOutput("busy",      busy,      mPend);
            if (mPend) begin
                checkOutput("out_data", out_data, expQ[0].data);
                checkOutput("out_ch",   out_ch,   expQ[0].ch);
                checkOutput("out_last", out_last, expQ[0].last);
            end
            mExpReady = !mPend || (expQ.size() == 1 && out_ready);
            checkOutput("in_ready", in_ready, mExpReady);
            if (mPend && out_ready) void'(expQ.pop_front());
            if (in_valid && mExpReady) queueFrame(in_data, mode, sel, curMask);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic m,
                                 input logic [IDX_W-1:0] s, input logic r);
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = r;
    endtask

    task automatic randomizeData();
        for (int c = 0; c < CHANNELS; c++) begin
            in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    // Present a frame and hold it until the DUT takes it; returns just after
    // the accepting edge.
    task automatic sendFrame(input logic m, input logic [IDX_W-1:0] s);
        bit done = 0;
        applyStimulus(1'b1, m, s, out_ready);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            nextCycle();
        end
        if (!done) checkOutput("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) done = 1;
            nextCycle();
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n   = 1'b0;
        in_data = '0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        repeat (3) nextCycle();
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] static select");
        for (int c = 0; c < CHANNELS; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'(c + 'h100);
        out_ready = 1'b1;
        sendFrame(1'b0, 4'd5);
        checkOutput("static_data", out_data, 'h105);
        checkOutput("static_ch",   out_ch,   5);
        checkOutput("static_last", out_last, 1);
        nextCycle();
        checkOutput("static_busy_fall", busy, 0);
        repeat (2) nextCycle();

        $display("[TB] scan back-to-back");
        randomizeData();
        sendFrame(1'b1, 4'd0);
        randomizeData();
        sendFrame(1'b1, 4'd0);
        waitDrain();

        $display("[TB] backpressure");
        randomizeData();
        sendFrame(1'b1, 4'd0);
        for (int i = 0; i < 200 && expQ.size() > 0; i++) begin
            out_ready = pat[i % 4];
            in_valid  = 1'b1;
            nextCycle();
        end
        in_valid = 1'b0;
        waitDrain();

        $display("[TB] negative sample");
        randomizeData();
        in_data[3*WIDTH +: WIDTH] = 19'h40000;
        sendFrame(1'b0, 4'd3);
        checkOutput("neg_data", out_data, 'h40000);
        waitDrain();

        $display("[TB] reset mid-frame");
        randomizeData();
        sendFrame(1'b1, 4'd0);
        repeat (7) nextCycle();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_busy",  busy,      0);
        randomizeData();
        sendFrame(1'b1, 4'd0);
        checkOutput("restart_ch", out_ch, 0);
        waitDrain();

`ifdef BEAM_CHAN_MASK_EN
        $display("[TB] channel mask");
        chMask = 16'h8421;
        randomizeData();
        sendFrame(1'b1, 4'd0);
        waitDrain();
        chMask = '0;
        sendFrame(1'b1, 4'd0);
        checkOutput("zero_mask_valid", out_valid, 0);
        checkOutput("zero_mask_ready", in_ready,  1);
        waitDrain();
        chMask = '1;
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                          IDX_W'($urandom), ($urandom_range(0, 3) != 0));
            randomizeData();
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef BEAM_CHAN_MASK_EN
            chMask = ($urandom_range(0, 9) == 0) ? '0 : CHANNELS'($urandom);
`endif
            nextCycle();
        end
        rst_n = 1'b1;
        waitDrain();
        checkOutput("final_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
